// File: rtl/regwatch_checker_if.sv
// Snooped CPU register-file write port.
// Single-cycle writes: wb_en qualifies wb_addr/wb_data on the rising clk edge, no backpressure.
interface regwatch_checker_if;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    modport master (output wb_en, output wb_addr, output wb_data);
    modport slave  (input  wb_en, input  wb_addr, input  wb_data);
endinterface

// File: rtl/regwatch_checker.sv
// Register-watch checker: shadows CPU register writes and walks an external check table,
// waiting on a flag register per entry and comparing an expected register value.
module regwatch_checker #(
    parameter int NUM_CHECKS     = 16,
    parameter int TIMEOUT_CYCLES = 50,
    parameter int IDX_W          = $clog2(NUM_CHECKS)
) (
    input  logic             clk,
    input  logic             rst,
    regwatch_checker_if.slave wb,
    output logic [IDX_W-1:0] chk_idx,
    input  logic [4:0]       chk_flag_reg,
    input  logic [31:0]      chk_flag_val,
    input  logic [4:0]       chk_reg,
    input  logic [31:0]      chk_exp,
    input  logic             chk_last,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [10:0]      fail_test,
    output logic [31:0]      fail_got,
    output logic [10:0]      pass_count,
    output logic [2:0]       dbg_state
);

    localparam logic [2:0] RUN_WAIT  = 3'd0;
    localparam logic [2:0] RUN_CHECK = 3'd1;
    localparam logic [2:0] PASS      = 3'd2;
    localparam logic [2:0] FAIL      = 3'd3;
    localparam logic [2:0] TIMEOUT   = 3'd4;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);

    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [31:0]   shadow [32];
    logic [31:0]   flag_rd;
    logic [31:0]   chk_rd;
    logic          timer_expired;
    logic          running;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) shadow[i] <= '0;
        end else if (wb.wb_en && wb.wb_addr != 5'd0) begin
            shadow[wb.wb_addr] <= wb.wb_data;
        end
    end

    assign flag_rd = (chk_flag_reg == 5'd0) ? 32'd0 : shadow[chk_flag_reg];
    assign chk_rd  = (chk_reg == 5'd0)      ? 32'd0 : shadow[chk_reg];

    // Timer saturates at its last value so an expiry masked by a check result
    // is still seen in the following RUN_WAIT cycle.
    assign running       = (state == RUN_WAIT) || (state == RUN_CHECK);
    assign timer_expired = (timer >= TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN_WAIT;
            chk_idx    <= '0;
            timer      <= '0;
            pass_count <= '0;
            fail_test  <= '0;
            fail_got   <= '0;
        end else begin
            if (running && !timer_expired) timer <= timer + 1'b1;
            case (state)
                RUN_WAIT: begin
                    if (timer_expired)               state <= TIMEOUT;
                    else if (flag_rd == chk_flag_val) state <= RUN_CHECK;
                end
                RUN_CHECK: begin
                    if (chk_rd == chk_exp) begin
                        pass_count <= pass_count + 11'd1;
                        if (chk_last || chk_idx == LAST_IDX) begin
                            state <= PASS;
                        end else begin
                            chk_idx <= chk_idx + 1'b1;
                            state   <= RUN_WAIT;
                        end
                    end else begin
                        state     <= FAIL;
                        fail_test <= 11'(chk_idx) + 11'd1;
                        fail_got  <= chk_rd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pass      = (state == PASS);
    assign fail      = (state == FAIL);
    assign timeout   = (state == TIMEOUT);
    assign done      = pass | fail | timeout;
    assign dbg_state = state;

endmodule

// File: tb/tb_regwatch_checker.sv
// Directed bench for regwatch_checker: a bench-side check table answers chk_idx,
// writes are driven through the snoop interface, results compared to hand-derived values.
module tb_regwatch_checker;

    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [IDX_W-1:0] chk_idx;
    logic [4:0]       chk_flag_reg;
    logic [31:0]      chk_flag_val;
    logic [4:0]       chk_reg;
    logic [31:0]      chk_exp;
    logic             chk_last;
    logic             done, pass, fail, timeout;
    logic [10:0]      fail_test, pass_count;
    logic [31:0]      fail_got;
    logic [2:0]       dbg_state;
    logic             use_b = 1'b0;
    int               checks = 0;
    int               errors = 0;

    regwatch_checker_if wb_bus ();

    regwatch_checker #(.NUM_CHECKS(16), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst(rst), .wb(wb_bus.slave),
        .chk_idx(chk_idx), .chk_flag_reg(chk_flag_reg), .chk_flag_val(chk_flag_val),
        .chk_reg(chk_reg), .chk_exp(chk_exp), .chk_last(chk_last),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_test(fail_test), .fail_got(fail_got), .pass_count(pass_count),
        .dbg_state(dbg_state)
    );

    always #10 clk = ~clk;

    // Table A: three entries on x20/x1/x2. Table B: a single x0 self-check.
    // Unused rows wait on x31 for a value never written.
    always_comb begin
        chk_flag_reg = 5'd31;
        chk_flag_val = 32'hFFFF_FFFF;
        chk_reg      = 5'd0;
        chk_exp      = 32'd0;
        chk_last     = 1'b0;
        if (use_b) begin
            if (chk_idx == 4'd0) begin
                chk_flag_reg = 5'd0; chk_flag_val = 32'd0;
                chk_reg = 5'd0; chk_exp = 32'd0; chk_last = 1'b1;
            end
        end else begin
            case (chk_idx)
                4'd0: begin chk_flag_reg = 5'd20; chk_flag_val = 32'd1;
                            chk_reg = 5'd1; chk_exp = 32'd300; chk_last = 1'b0; end
                4'd1: begin chk_flag_reg = 5'd20; chk_flag_val = 32'd2;
                            chk_reg = 5'd1; chk_exp = 32'd500; chk_last = 1'b0; end
                4'd2: begin chk_flag_reg = 5'd20; chk_flag_val = 32'd2;
                            chk_reg = 5'd2; chk_exp = 32'd100; chk_last = 1'b1; end
                default: ;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wb_bus.wb_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_bus.wb_en = 1'b1; wb_bus.wb_addr = a; wb_bus.wb_data = d;
        @(posedge clk); #1;
        wb_bus.wb_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic play_a();
        wr(5'd1, 32'd300);  idle(2);
        wr(5'd20, 32'd1);   idle(2);
        wr(5'd1, 32'd500);  idle(2);
        wr(5'd2, 32'd100);  idle(2);
        wr(5'd20, 32'd2);   idle(6);
    endtask

    initial begin
        wb_bus.wb_en = 1'b0; wb_bus.wb_addr = '0; wb_bus.wb_data = '0;

        // Reset state
        do_reset();
        check_eq("rst_done",      32'(done), 32'd0);
        check_eq("rst_pass",      32'(pass), 32'd0);
        check_eq("rst_fail",      32'(fail), 32'd0);
        check_eq("rst_timeout",   32'(timeout), 32'd0);
        check_eq("rst_idx",       32'(chk_idx), 32'd0);
        check_eq("rst_pcount",    32'(pass_count), 32'd0);
        check_eq("rst_fail_test", 32'(fail_test), 32'd0);
        check_eq("rst_fail_got",  fail_got, 32'd0);
        check_eq("rst_state",     32'(dbg_state), 32'd0);

        // All three entries pass
        wr(5'd1, 32'd300);  idle(2);
        wr(5'd20, 32'd1);   idle(2);
        check_eq("a_e0_pcount", 32'(pass_count), 32'd1);
        check_eq("a_e0_idx",    32'(chk_idx), 32'd1);
        wr(5'd1, 32'd500);  idle(2);
        wr(5'd2, 32'd100);  idle(2);
        wr(5'd20, 32'd2);   idle(6);
        check_eq("a_pass",   32'(pass), 32'd1);
        check_eq("a_pcount", 32'(pass_count), 32'd3);
        check_eq("a_fail",   32'(fail), 32'd0);
        check_eq("a_done",   32'(done), 32'd1);

        // Mismatch on entry 0
        do_reset();
        wr(5'd1, 32'd400);  idle(2);
        wr(5'd20, 32'd1);   idle(4);
        check_eq("mm_fail",      32'(fail), 32'd1);
        check_eq("mm_fail_test", 32'(fail_test), 32'd1);
        check_eq("mm_fail_got",  fail_got, 32'd400);
        check_eq("mm_done",      32'(done), 32'd1);
        check_eq("mm_pcount",    32'(pass_count), 32'd0);
        check_eq("mm_pass",      32'(pass), 32'd0);

        // Timeout exactly 50 edges after release
        do_reset();
        idle(49);
        check_eq("to_before", 32'(timeout), 32'd0);
        idle(1);
        check_eq("to_at50",   32'(timeout), 32'd1);
        check_eq("to_done",   32'(done), 32'd1);
        check_eq("to_pass",   32'(pass), 32'd0);
        idle(5);
        check_eq("to_sticky", 32'(timeout), 32'd1);

        // x0 is hard-wired to zero
        use_b = 1'b1;
        do_reset();
        wr(5'd0, 32'd7);
        check_eq("x0_pass_early", 32'(pass), 32'd0);
        idle(1);
        check_eq("x0_pass",   32'(pass), 32'd1);
        check_eq("x0_pcount", 32'(pass_count), 32'd1);
        use_b = 1'b0;

        // Reset mid-sequence then replay
        do_reset();
        wr(5'd1, 32'd300);  idle(2);
        wr(5'd20, 32'd1);   idle(2);
        check_eq("rr_mid_pcount", 32'(pass_count), 32'd1);
        do_reset();
        check_eq("rr_pcount0", 32'(pass_count), 32'd0);
        check_eq("rr_idx0",    32'(chk_idx), 32'd0);
        play_a();
        check_eq("rr_pass",   32'(pass), 32'd1);
        check_eq("rr_pcount", 32'(pass_count), 32'd3);

        // Write during reset must be dropped (x20=1 would trigger a failing check)
        rst = 1'b1;
        wb_bus.wb_en = 1'b1; wb_bus.wb_addr = 5'd20; wb_bus.wb_data = 32'd1;
        @(posedge clk); #1;
        rst = 1'b0; wb_bus.wb_en = 1'b0;
        idle(4);
        check_eq("rstwr_state", 32'(dbg_state), 32'd0);
        check_eq("rstwr_done",  32'(done), 32'd0);

        // Entry 1 mismatch on the same edge the timer expires
        do_reset();
        wr(5'd1, 32'd300);
        wr(5'd20, 32'd1);
        idle(45);
        wr(5'd20, 32'd2);
        idle(1);
        check_eq("race_state_chk", 32'(dbg_state), 32'd1);
        idle(1);
        check_eq("race_fail",      32'(fail), 32'd1);
        check_eq("race_timeout",   32'(timeout), 32'd0);
        check_eq("race_fail_test", 32'(fail_test), 32'd2);
        check_eq("race_fail_got",  fail_got, 32'd300);
        check_eq("race_pcount",    32'(pass_count), 32'd1);
        idle(5);
        check_eq("race_sticky",    32'(fail), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
